// File: rtl/day10_pkg.sv
// Shared types and width helpers for the Day 10 minimum-presses solver.
package day10_pkg;

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} solver_state_e;

   // Bits needed to hold the values 0..n, never narrower than one bit.
   function automatic int count_width(input int n);
      return (n <= 1) ? 1 : $clog2(n + 1);
   endfunction

   // Mask with the low n bits set, limited to width bits; callers cast to their own width.
   function automatic logic [63:0] mask_from_count(input int n, input int width);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < n && i < width) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/day10_input_if.sv
// One Day 10 machine description as produced by the parser/loader stage.
interface day10_input_if
   import day10_pkg::*;
#(
   parameter int MAX_NUM_LIGHTS  = 16,
   parameter int MAX_NUM_BUTTONS = 16
);
   localparam int NUM_LIGHTS_W  = count_width(MAX_NUM_LIGHTS);
   localparam int NUM_BUTTONS_W = count_width(MAX_NUM_BUTTONS);

   logic [NUM_LIGHTS_W-1:0]   num_lights;
   logic [NUM_BUTTONS_W-1:0]  num_buttons;
   logic [MAX_NUM_LIGHTS-1:0] buttons [MAX_NUM_BUTTONS];
   logic [MAX_NUM_LIGHTS-1:0] target_lights_arrangement;

   modport as_input  (input  num_lights, num_buttons, buttons, target_lights_arrangement);
   modport as_output (output num_lights, num_buttons, buttons, target_lights_arrangement);
endinterface

// File: rtl/day10_trailing_zeros.sv
// Priority encoder: index of the lowest set bit of value (0 when value is zero).
module day10_trailing_zeros
   import day10_pkg::*;
#(
   parameter  int WIDTH   = 17,
   localparam int INDEX_W = count_width(WIDTH - 1)
)(
   input  logic [WIDTH-1:0]   value,
   output logic [INDEX_W-1:0] index
);

   // Scan downwards so the lowest set bit is the last to write index.
   always_comb begin
      index = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (value[i]) index = INDEX_W'(i);
      end
   end

endmodule

// File: rtl/day10_min_presses_solver.sv
// Gray-code exhaustive search for the smallest button subset whose XOR hits the target.
// Optional DAY10_SOLVER_EARLY_EXIT_EN: stop early on a best of 0/1 and report cycles_used.
module day10_min_presses_solver
   import day10_pkg::*;
#(
   parameter  int MAX_NUM_LIGHTS    = 16,
   parameter  int MAX_NUM_BUTTONS   = 16,
   localparam int MAX_NUM_BUTTONS_W = count_width(MAX_NUM_BUTTONS)
)(
   input  logic                         clk,
   input  logic                         rst,
   day10_input_if.as_input              puzzle,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         solvable,
   output logic [MAX_NUM_BUTTONS_W-1:0] min_presses
`ifdef DAY10_SOLVER_EARLY_EXIT_EN
   ,
   output logic [MAX_NUM_BUTTONS:0]     cycles_used
`endif
);

   localparam int IDX_W = MAX_NUM_BUTTONS + 1;
   localparam int K_W   = count_width(IDX_W - 1);
   localparam int CNT_W = MAX_NUM_BUTTONS_W;

   solver_state_e             state, state_next;
   logic [IDX_W-1:0]          idx_r, last_idx_r, idx_next, gray_r, last_idx_in;
   logic [MAX_NUM_LIGHTS-1:0] acc_r, target_r, light_mask, btn_sel;
   logic [MAX_NUM_LIGHTS-1:0] btn_r [MAX_NUM_BUTTONS];
   logic [CNT_W-1:0]          cnt_r, best_r, nb_sat;
   logic                      best_valid_r, accept, hit, at_last, gray_bit, search_done;
   logic [K_W-1:0]            k;

   assign light_mask = MAX_NUM_LIGHTS'(mask_from_count(int'(puzzle.num_lights), MAX_NUM_LIGHTS));
   assign nb_sat     = (puzzle.num_buttons > CNT_W'(MAX_NUM_BUTTONS)) ? CNT_W'(MAX_NUM_BUTTONS)
                                                                      : puzzle.num_buttons;
   assign last_idx_in = (IDX_W'(1) << nb_sat) - IDX_W'(1);

   assign idx_next = idx_r + IDX_W'(1);
   assign gray_r   = idx_r ^ (idx_r >> 1);

   day10_trailing_zeros #(.WIDTH(IDX_W)) u_tz (
      .value (idx_next),
      .index (k)
   );

   // The button to toggle and the current gray bit both come from the trailing-zero index.
   always_comb begin
      btn_sel  = '0;
      gray_bit = 1'b0;
      for (int i = 0; i < MAX_NUM_BUTTONS; i++) begin
         if (k == K_W'(i)) btn_sel = btn_r[i];
      end
      for (int i = 0; i < IDX_W; i++) begin
         if (k == K_W'(i)) gray_bit = gray_r[i];
      end
   end

   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;
   assign hit      = (acc_r == target_r) && (!best_valid_r || cnt_r < best_r);
   assign at_last  = (idx_r == last_idx_r);

`ifdef DAY10_SOLVER_EARLY_EXIT_EN
   assign search_done = at_last ||
                        (best_valid_r && (best_r == CNT_W'(0) ||
                                          (best_r == CNT_W'(1) && idx_r >= last_idx_r)));
`else
   assign search_done = at_last;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = SEARCH;
         SEARCH:  if (search_done) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Puzzle capture on accept, then one gray step and one best-so-far update per SEARCH cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r        <= '0;
         last_idx_r   <= '0;
         acc_r        <= '0;
         target_r     <= '0;
         cnt_r        <= '0;
         best_r       <= '0;
         best_valid_r <= 1'b0;
         for (int i = 0; i < MAX_NUM_BUTTONS; i++) btn_r[i] <= '0;
      end else if (state == IDLE) begin
         if (accept) begin
            idx_r        <= '0;
            last_idx_r   <= last_idx_in;
            acc_r        <= '0;
            target_r     <= puzzle.target_lights_arrangement & light_mask;
            cnt_r        <= '0;
            best_r       <= '0;
            best_valid_r <= 1'b0;
            for (int i = 0; i < MAX_NUM_BUTTONS; i++) btn_r[i] <= puzzle.buttons[i] & light_mask;
         end
      end else if (state == SEARCH) begin
         if (hit) begin
            best_r       <= cnt_r;
            best_valid_r <= 1'b1;
         end
         if (!at_last) begin
            idx_r <= idx_next;
            acc_r <= acc_r ^ btn_sel;
            cnt_r <= gray_bit ? cnt_r - CNT_W'(1) : cnt_r + CNT_W'(1);
         end
      end
   end

`ifdef DAY10_SOLVER_EARLY_EXIT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          cycles_used <= '0;
      else if (state == IDLE && accept) cycles_used <= '0;
      else if (state == SEARCH)         cycles_used <= cycles_used + IDX_W'(1);
   end
`endif

   assign out_valid   = (state == DONE);
   assign solvable    = out_valid && best_valid_r;
   assign min_presses = solvable ? best_r : '0;

endmodule

// File: doc/day10_min_presses_solver.md
Name: day10_min_presses_solver

Overview:
- Consumes one Day 10 machine description per transaction from `day10_input_if` (as_input modport). Returns the minimum number of button presses whose XOR equals the target light arrangement.
- Sits directly downstream of the input parser/loader stage and upstream of the answer accumulator.
- Searches exhaustively with a Gray-code walk: exactly one button toggles per cycle, so each cycle costs one XOR and one ±1 count update.

Parameters:
- MAX_NUM_LIGHTS, 16, width of light/button masks.
- MAX_NUM_BUTTONS, 16, maximum buttons per machine; sets Gray counter width.
- MAX_NUM_BUTTONS_W, derived: MAX_NUM_BUTTONS<=1 ? 1 : $clog2(MAX_NUM_BUTTONS+1); press-count width.

Ports:
- clk  input  1  sole clock
- rst  input  1  asynchronous, active-high reset
- puzzle  interface  day10_input_if.as_input  num_lights, num_buttons, buttons[], target_lights_arrangement
- in_valid  input  1  puzzle fields valid
- in_ready  output  1  block can accept a puzzle
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- solvable  output  1  some subset reaches target
- min_presses  output  MAX_NUM_BUTTONS_W  minimum subset size; 0 when !solvable

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, in_ready=0 during reset then 1, out_valid=0, solvable=0, min_presses=0, all internal registers cleared.
- States IDLE -> SEARCH -> DONE -> IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, capture into local registers; puzzle may change afterwards:
    - num_buttons, saturated to MAX_NUM_BUTTONS.
    - buttons[i] AND light_mask, where light_mask = low num_lights bits set.
    - target AND light_mask.
  - Initialise idx=0, acc=0, cnt=0, best_valid=0. Go to SEARCH.
- SEARCH:
  - in_ready=0.
  - Each cycle, compare: if acc==target and (!best_valid or cnt<best), set best=cnt and best_valid=1.
  - Terminate: if idx==2^num_buttons-1, go to DONE.
  - Otherwise advance:
    - idx<=idx+1.
    - k = trailing-zero index of (idx+1).
    - acc^=buttons[k].
    - cnt +=1 if gray bit k was 0, else -=1. Gray = idx^(idx>>1).
  - SEARCH lasts exactly 2^num_buttons cycles.
  - num_buttons=0 gives 1 cycle, evaluating only the empty set.
  - Buttons with index >= num_buttons are never toggled.
- DONE:
  - out_valid=1, solvable=best_valid, min_presses = best_valid ? best : 0.
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE. out_valid drops the next cycle and in_ready rises the same cycle.
- Latency: the accept edge to out_valid high is 2^num_buttons+1 cycles.
- Throughput: one puzzle per 2^num_buttons+2 cycles minimum, with no overlap.
- idx width is MAX_NUM_BUTTONS+1 bits so the terminal value never wraps.
- num_lights=0: mask is empty, target=0, empty set matches; result solvable=1, min_presses=0.
- Reset mid-SEARCH or mid-DONE: returns to IDLE immediately. The pending result is discarded and out_valid=0.
- in_valid asserted outside IDLE is ignored. The upstream stage must hold it until in_ready.

Optional Feature:
- Macro: DAY10_SOLVER_EARLY_EXIT_EN.
- Defined:
  - Add a register holding the minimum set bit count over the remaining Gray codes? No. The rule is simpler: track visited press counts.
  - The search terminates to DONE the cycle after best_valid is set with best==0.
  - It also terminates when best==1 once all single-button subsets have been evaluated, i.e. idx >= 2^num_buttons-1. Otherwise behaviour is unchanged.
  - Add output port cycles_used (MAX_NUM_BUTTONS+1 bits), equal to SEARCH cycles spent and valid with out_valid.
- Undefined: no cycles_used port; SEARCH always runs the full 2^num_buttons cycles.

Decomposition:
- Package day10_pkg holds:
  - the width-derivation functions: clog2-with-floor-1 and the mask-from-count function;
  - typedef solver_state_e {IDLE, SEARCH, DONE}.
- Sub-module day10_trailing_zeros: combinational priority encoder returning the index of the lowest set bit of idx+1. Parameterised by MAX_NUM_BUTTONS+1.

Test Plan:
- Example machine, 4 lights, target .##. = 4'b0110:
  - Buttons 1000, 1010, 0100, 1100, 0101, 0011; num_buttons=6.
  - Expect solvable=1, min_presses=2, out_valid exactly 65 cycles after accept.
- Unsolvable: num_lights=2, one button 2'b01, target 2'b10 -> solvable=0, min_presses=0, out_valid 3 cycles after accept.
- Zero target / zero buttons: num_buttons=0, target=0 -> solvable=1, min_presses=0 after 2 cycles. Same puzzle with target=1 -> solvable=0.
- Masking: num_lights=3, button 16'hFFF9, target 3'b001 -> min_presses=1. Bits above num_lights are ignored.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Pulse out_ready -> IDLE next cycle, next puzzle accepted.
- Reset mid-SEARCH of the 6-button case at cycle 20 -> out_valid=0 and in_ready=1 after release. A new puzzle then produces the correct independent result.
